// File: rtl/counter_sync_pos_rst_w_pos_en_down4bit.sv
// Synchronous down counter with parallel load, reload register,
// terminal-count (zero) flag and a one-cycle borrow pulse.
// A wrap (decrement taken from 0) lands on all-ones by default. With
// COUNTER_DOWN_AUTO_RELOAD_EN defined, a wrap reloads the last loaded value
// instead, which gives a programmable period of rld+1 enabled cycles.
// Edge priority: reset, then load, then enable, then hold.
module counter_sync_pos_rst_w_pos_en_down4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             zero_q, zero_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] wrap_value;

`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
    // Wrap returns to the reload value, giving a programmable period.
    assign wrap_value = rld_q;
`else
    // Wrap rolls over to all-ones; the reload register is kept but unread.
    assign wrap_value = '1;
    logic rld_unused;
    assign rld_unused = ^rld_q;
`endif

    // Next-state: load beats enable; wrap raises borrow; zero follows the new count.
    always_comb begin
        out_d    = out_q;
        rld_d    = rld_q;
        borrow_d = 1'b0;
        if (load) begin
            out_d = load_value;
            rld_d = load_value;
        end else if (enable) begin
            if (out_q == '0) begin
                out_d    = wrap_value;
                borrow_d = 1'b1;
            end else begin
                out_d = out_q - ONE;
            end
        end
        zero_d = (out_d == '0);
    end

    // State registers; synchronous reset clears the count and reload value.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= '0;
            rld_q    <= '0;
            zero_q   <= 1'b1;
            borrow_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            rld_q    <= rld_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end

    assign out    = out_q;
    assign zero   = zero_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_counter_sync_pos_rst_w_pos_en_down4bit.sv
`timescale 1ns/100ps
// Bench for the 4-bit down counter. Builds with or without
// COUNTER_DOWN_AUTO_RELOAD_EN; build-specific scenarios follow the macro.
module tb_counter_sync_pos_rst_w_pos_en_down4bit;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] out;
    logic       zero;
    logic       borrow;
    logic [3:0] out1;
    logic       zero1;
    logic       borrow1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] out;
        logic       zero;
        logic       borrow;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic [3:0] eo;
        logic       ez;
        logic       eb;
    } stim_t;

    exp_t exp_q[$];

    counter_sync_pos_rst_w_pos_en_down4bit #(.WIDTH(4)) u0 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .out        (out),
        .zero       (zero),
        .borrow     (borrow)
    );

    // Cascade stage: enabled by the borrow of stage 0.
    counter_sync_pos_rst_w_pos_en_down4bit #(.WIDTH(4)) u1 (
        .clock      (clock),
        .reset      (reset),
        .enable     (borrow),
        .load       (load),
        .load_value (load_value),
        .out        (out1),
        .zero       (zero1),
        .borrow     (borrow1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs (called at a falling edge), record the
    // expectation, then return at the next falling edge.
    task automatic apply(input stim_t s);
        exp_t e;
        reset      = s.rst;
        load       = s.ld;
        load_value = s.lv;
        enable     = s.en;
        e.out    = s.eo;
        e.zero   = s.ez;
        e.borrow = s.eb;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        stim_t t[4] = '{
            '{1'b1, 1'b1, 4'hA, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0}
        };
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply(t[i]);
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out || zero !== e.zero || borrow !== e.borrow) begin
                errors++;
                $display("FAIL reset[%0d]: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                         i, out, zero, borrow, e.out, e.zero, e.borrow);
            end
        end
    endtask

    task automatic test_count();
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
        stim_t t[8] = '{
            '{1'b0, 1'b1, 4'h2, 1'b0, 4'h2, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0}
        };
`else
        stim_t t[6] = '{
            '{1'b0, 1'b1, 4'h3, 1'b0, 4'h3, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0}
        };
`endif
        exp_t e;
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out || zero !== e.zero || borrow !== e.borrow) begin
                errors++;
                $display("FAIL count[%0d]: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                         i, out, zero, borrow, e.out, e.zero, e.borrow);
            end
        end
    endtask

    task automatic test_load_priority();
        stim_t t[2] = '{
            '{1'b0, 1'b1, 4'h5, 1'b0, 4'h5, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0}
        };
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            apply(t[i]);
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out || zero !== e.zero || borrow !== e.borrow) begin
                errors++;
                $display("FAIL load_priority[%0d]: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                         i, out, zero, borrow, e.out, e.zero, e.borrow);
            end
        end
    endtask

    task automatic test_enable_toggle_and_reset();
        stim_t t[7] = '{
            '{1'b0, 1'b1, 4'h7, 1'b0, 4'h7, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h6, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b0, 4'h5, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'h4, 1'b0, 4'h4, 1'b0, 1'b0},
            '{1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0}
        };
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            apply(t[i]);
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out || zero !== e.zero || borrow !== e.borrow) begin
                errors++;
                $display("FAIL toggle_reset[%0d]: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                         i, out, zero, borrow, e.out, e.zero, e.borrow);
            end
        end
    endtask

    // Consecutive loads: the second must win in both count and reload value.
    task automatic test_back_to_back();
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
        stim_t t[7] = '{
            '{1'b0, 1'b1, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1}
        };
`else
        stim_t t[7] = '{
            '{1'b0, 1'b1, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1}
        };
`endif
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            apply(t[i]);
            e = exp_q.pop_front();
            checks++;
            if (out !== e.out || zero !== e.zero || borrow !== e.borrow) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                         i, out, zero, borrow, e.out, e.zero, e.borrow);
            end
        end
    endtask

`ifndef COUNTER_DOWN_AUTO_RELOAD_EN
    // Stage 1 decrements once per 16 enabled edges of stage 0.
    task automatic test_cascade();
        exp_t  e;
        stim_t s;
        s = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0};
        apply(s);
        e = exp_q.pop_front();
        checks++;
        if (out1 !== e.out || zero1 !== e.zero || borrow1 !== e.borrow) begin
            errors++;
            $display("FAIL cascade_load: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                     out1, zero1, borrow1, e.out, e.zero, e.borrow);
        end
        for (int edge_n = 1; edge_n <= 20; edge_n++) begin
            s.rst = 1'b0; s.ld = 1'b0; s.lv = 4'h0; s.en = 1'b1;
            s.eo = (edge_n < 2) ? 4'h0 : (edge_n < 18) ? 4'hF : 4'hE;
            s.ez = (edge_n < 2);
            s.eb = (edge_n == 2);
            apply(s);
            e = exp_q.pop_front();
            checks++;
            if (out1 !== e.out || zero1 !== e.zero || borrow1 !== e.borrow) begin
                errors++;
                $display("FAIL cascade[edge %0d]: got out=%h zero=%b borrow=%b, expected out=%h zero=%b borrow=%b",
                         edge_n, out1, zero1, borrow1, e.out, e.zero, e.borrow);
            end
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = 4'h0;
        @(negedge clock);
        @(negedge clock);
        test_reset();
        test_count();
        test_load_priority();
        test_enable_toggle_and_reset();
        test_back_to_back();
`ifndef COUNTER_DOWN_AUTO_RELOAD_EN
        test_cascade();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
